// File: rtl/cond_unit_if.sv
// Instruction/result channel of the condition-check stage: upstream instruction
// handshake, gated control outputs with backpressure, and the execution counters.
interface cond_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       cond;
  logic [1:0]       flag_w;
  logic             pcs;
  logic             reg_w;
  logic             mem_w;
  logic             no_write;
  logic [3:0]       alu_flags;
  logic             out_valid;
  logic             out_ready;
  logic             pc_src;
  logic             reg_write;
  logic             mem_write;
  logic             cond_ex;
  logic [3:0]       flags;
  logic             cnt_clr;
  logic [CNT_W-1:0] exec_cnt;
  logic [CNT_W-1:0] skip_cnt;

  // Producer of instructions / consumer of results (datapath side)
  modport master (
    output in_valid, cond, flag_w, pcs, reg_w, mem_w, no_write, alu_flags,
    output out_ready, cnt_clr,
    input  in_ready, out_valid, pc_src, reg_write, mem_write, cond_ex, flags,
    input  exec_cnt, skip_cnt
  );

  // The condition unit itself
  modport slave (
    input  in_valid, cond, flag_w, pcs, reg_w, mem_w, no_write, alu_flags,
    input  out_ready, cnt_clr,
    output in_ready, out_valid, pc_src, reg_write, mem_write, cond_ex, flags,
    output exec_cnt, skip_cnt
  );
endinterface

// File: rtl/cond_unit.sv
// Condition-check and flag-register stage: evaluates ARM-style condition codes
// against committed {N,Z,C,V}, gates writes and registers them behind valid/ready.
module cond_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  cond_unit_if.slave  bus
);

  localparam int unsigned FLAG_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [3:0] {
    C_EQ = 4'd0,  C_NE = 4'd1,  C_CS = 4'd2,  C_CC = 4'd3,
    C_MI = 4'd4,  C_PL = 4'd5,  C_VS = 4'd6,  C_VC = 4'd7,
    C_HI = 4'd8,  C_LS = 4'd9,  C_GE = 4'd10, C_LT = 4'd11,
    C_GT = 4'd12, C_LE = 4'd13, C_AL = 4'd14, C_NV = 4'd15
  } cond_e;

  typedef struct packed {
    logic pc_src;
    logic reg_write;
    logic mem_write;
    logic cond_ex;
  } ctl_t;

  logic [FLAG_W-1:0] flags_q, flags_d;
  ctl_t              ctl_q, ctl_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  exec_q, exec_d;
  logic [CNT_W-1:0]  skip_q, skip_d;
  logic              xfer;
  logic              ex;

  // Condition evaluation on {N,Z,C,V}
  function automatic logic cond_eval(input logic [3:0] c, input logic [FLAG_W-1:0] f);
    logic n, z, cy, v;
    logic r;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (cond_e'(c))
      C_EQ:    r = z;
      C_NE:    r = !z;
      C_CS:    r = cy;
      C_CC:    r = !cy;
      C_MI:    r = n;
      C_PL:    r = !n;
      C_VS:    r = v;
      C_VC:    r = !v;
      C_HI:    r = cy && !z;
      C_LS:    r = !cy || z;
      C_GE:    r = (n == v);
      C_LT:    r = (n != v);
      C_GT:    r = !z && (n == v);
      C_LE:    r = z || (n != v);
      C_AL:    r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign xfer         = bus.in_valid && bus.in_ready;
  assign ex           = cond_eval(bus.cond, flags_q);

  // Next-state: flag commit, output register load/drain, saturating counters
  always_comb begin
    flags_d = flags_q;
    ctl_d   = ctl_q;
    valid_d = valid_q;
    exec_d  = exec_q;
    skip_d  = skip_q;

    if (xfer) begin
      if (ex && bus.flag_w[1]) flags_d[3:2] = bus.alu_flags[3:2];
      if (ex && bus.flag_w[0]) flags_d[1:0] = bus.alu_flags[1:0];

      ctl_d.pc_src    = bus.pcs && ex;
      ctl_d.reg_write = bus.reg_w && ex && !bus.no_write;
      ctl_d.mem_write = bus.mem_w && ex;
      ctl_d.cond_ex   = ex;
      valid_d         = 1'b1;

      if (ex) begin
        if (exec_q != CNT_MAX) exec_d = exec_q + CNT_W'(1);
      end else begin
        if (skip_q != CNT_MAX) skip_d = skip_q + CNT_W'(1);
      end
    end else if (bus.out_ready) begin
      // Drained: controls read as zero while nothing is held
      valid_d = 1'b0;
      ctl_d   = '0;
    end

    if (bus.cnt_clr) begin
      exec_d = '0;
      skip_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
      ctl_q   <= '0;
      valid_q <= 1'b0;
      exec_q  <= '0;
      skip_q  <= '0;
    end else begin
      flags_q <= flags_d;
      ctl_q   <= ctl_d;
      valid_q <= valid_d;
      exec_q  <= exec_d;
      skip_q  <= skip_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.pc_src    = ctl_q.pc_src;
  assign bus.reg_write = ctl_q.reg_write;
  assign bus.mem_write = ctl_q.mem_write;
  assign bus.cond_ex   = ctl_q.cond_ex;
  assign bus.flags     = flags_q;
  assign bus.exec_cnt  = exec_q;
  assign bus.skip_cnt  = skip_q;

endmodule

// File: tb/tb_cond_unit.sv
// Bench for cond_unit: hand-computed vector table streamed back-to-back into a
// scoreboard, plus stall, counter-clear and mid-stall reset sequences.
module tb_cond_unit;

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef struct {
    logic [3:0] cond;
    logic [1:0] fw;
    logic       pcs, rw, mw, nw;
    logic [3:0] alu;
    logic       clr;
    logic [3:0] ctl;    // {pc_src, reg_write, mem_write, cond_ex}
    logic [3:0] flags;  // committed flags after this instruction
  } vec_t;

  typedef struct {
    logic [3:0]       ctl;
    logic [3:0]       flags;
    logic [CNT_W-1:0] ex_cnt;
    logic [CNT_W-1:0] sk_cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cond_unit_if #(.CNT_W(CNT_W)) bus ();
  cond_unit #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  vec_t tbl[$];
  exp_t sbq[$];
  int n_vec = 0;
  int n_err = 0;
  logic [CNT_W-1:0] m_ex = '0;
  logic [CNT_W-1:0] m_sk = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic vec_t mkv(input logic [3:0] c, input logic [1:0] fw,
                               input logic pcs, input logic rw, input logic mw, input logic nw,
                               input logic [3:0] alu, input logic [3:0] ctl, input logic [3:0] fl);
    vec_t v;
    v.cond = c; v.fw = fw; v.pcs = pcs; v.rw = rw; v.mw = mw; v.nw = nw;
    v.alu = alu; v.clr = 1'b0; v.ctl = ctl; v.flags = fl;
    return v;
  endfunction

  task automatic push_exp(input vec_t v);
    exp_t e;
    if (v.clr) begin
      m_ex = '0;
      m_sk = '0;
    end else if (v.ctl[0]) begin
      if (m_ex != CMAX) m_ex = m_ex + 1'b1;
    end else begin
      if (m_sk != CMAX) m_sk = m_sk + 1'b1;
    end
    e.ctl = v.ctl; e.flags = v.flags; e.ex_cnt = m_ex; e.sk_cnt = m_sk;
    sbq.push_back(e);
  endtask

  task automatic drive(input vec_t v);
    bus.in_valid = 1'b1;   bus.cond = v.cond;  bus.flag_w = v.fw;
    bus.pcs = v.pcs;       bus.reg_w = v.rw;   bus.mem_w = v.mw;
    bus.no_write = v.nw;   bus.alu_flags = v.alu; bus.cnt_clr = v.clr;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0; bus.cond = 4'd0; bus.flag_w = 2'b00;
    bus.pcs = 1'b0; bus.reg_w = 1'b0; bus.mem_w = 1'b0; bus.no_write = 1'b0;
    bus.alu_flags = 4'h0; bus.cnt_clr = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the transfer edge
  task automatic send(input vec_t v);
    bit done;
    done = 1'b0;
    drive(v);
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.in_ready) begin
        push_exp(v);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: in_ready never rose for cond=%0d", v.cond);
    end
  endtask

  // Scoreboard consumer: a result leaves on the coming edge when valid && ready
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL sb_underflow: unexpected output ctl=%0h", {bus.pc_src, bus.reg_write, bus.mem_write, bus.cond_ex});
      end else begin
        e = sbq.pop_front();
        check("out_ctl", {bus.pc_src, bus.reg_write, bus.mem_write, bus.cond_ex}, e.ctl);
        check("out_flags", bus.flags, e.flags);
        check("exec_cnt", bus.exec_cnt, e.ex_cnt);
        check("skip_cnt", bus.skip_cnt, e.sk_cnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    idle();
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_ctl", {bus.pc_src, bus.reg_write, bus.mem_write, bus.cond_ex}, 0);
    check("rst_flags", bus.flags, 0);
    check("rst_cnts", {bus.exec_cnt, bus.skip_cnt}, 0);
    check("rst_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // cond, fw, pcs, rw, mw, nw, alu, {pc,rw,mw,ex}, flags-after
    tbl.push_back(mkv(14, 2'b11, 0, 1, 0, 0, 4'b0100, 4'b0101, 4'b0100));
    tbl.push_back(mkv( 0, 2'b00, 0, 0, 1, 0, 4'hf,    4'b0011, 4'b0100));
    tbl.push_back(mkv( 1, 2'b00, 0, 0, 1, 0, 4'hf,    4'b0000, 4'b0100));
    tbl.push_back(mkv(14, 2'b11, 0, 0, 0, 0, 4'b0000, 4'b0001, 4'b0000));
    tbl.push_back(mkv( 1, 2'b10, 0, 0, 0, 0, 4'b1111, 4'b0001, 4'b1100));
    tbl.push_back(mkv( 1, 2'b11, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b1100));
    tbl.push_back(mkv(14, 2'b11, 0, 0, 0, 0, 4'b1000, 4'b0001, 4'b1000));
    tbl.push_back(mkv(10, 2'b00, 1, 0, 0, 0, 4'hf,    4'b0000, 4'b1000));
    tbl.push_back(mkv(11, 2'b00, 1, 0, 0, 0, 4'hf,    4'b1001, 4'b1000));
    tbl.push_back(mkv(13, 2'b00, 0, 1, 0, 0, 4'hf,    4'b0101, 4'b1000));
    tbl.push_back(mkv(12, 2'b00, 0, 1, 0, 0, 4'hf,    4'b0000, 4'b1000));
    tbl.push_back(mkv(14, 2'b11, 0, 0, 0, 0, 4'b1101, 4'b0001, 4'b1101));
    tbl.push_back(mkv(12, 2'b00, 0, 0, 0, 0, 4'h0,    4'b0000, 4'b1101));
    tbl.push_back(mkv(13, 2'b00, 0, 0, 0, 0, 4'h0,    4'b0001, 4'b1101));
    tbl.push_back(mkv(15, 2'b00, 1, 0, 0, 0, 4'h0,    4'b0000, 4'b1101));
    tbl.push_back(mkv(14, 2'b00, 0, 1, 0, 1, 4'h0,    4'b0001, 4'b1101));
    tbl.push_back(mkv( 8, 2'b00, 0, 0, 0, 0, 4'h0,    4'b0000, 4'b1101));
    tbl.push_back(mkv( 9, 2'b00, 0, 0, 0, 0, 4'h0,    4'b0001, 4'b1101));
    tbl.push_back(mkv( 2, 2'b00, 0, 0, 0, 0, 4'h0,    4'b0000, 4'b1101));
    tbl.push_back(mkv( 3, 2'b00, 0, 0, 0, 0, 4'h0,    4'b0001, 4'b1101));
    tbl.push_back(mkv( 4, 2'b00, 0, 0, 0, 0, 4'h0,    4'b0001, 4'b1101));
    tbl.push_back(mkv( 5, 2'b00, 0, 0, 0, 0, 4'h0,    4'b0000, 4'b1101));
    tbl.push_back(mkv( 6, 2'b00, 0, 0, 0, 0, 4'h0,    4'b0001, 4'b1101));
    tbl.push_back(mkv( 7, 2'b00, 0, 0, 0, 0, 4'h0,    4'b0000, 4'b1101));
    tbl.push_back(mkv(14, 2'b01, 0, 0, 0, 0, 4'b0010, 4'b0001, 4'b1110));
    tbl.push_back(mkv( 8, 2'b00, 0, 0, 0, 0, 4'h0,    4'b0000, 4'b1110));
    tbl.push_back(mkv( 2, 2'b00, 0, 0, 0, 0, 4'h0,    4'b0001, 4'b1110));
    tbl.push_back(mkv(14, 2'b11, 0, 0, 0, 0, 4'b0010, 4'b0001, 4'b0010));
    tbl.push_back(mkv( 8, 2'b00, 0, 0, 0, 0, 4'hf,    4'b0001, 4'b0010));
    tbl.push_back(mkv( 9, 2'b00, 0, 0, 0, 0, 4'hf,    4'b0000, 4'b0010));
    tbl.push_back(mkv(10, 2'b00, 0, 0, 0, 0, 4'hf,    4'b0001, 4'b0010));
    tbl.push_back(mkv(12, 2'b00, 0, 0, 0, 0, 4'hf,    4'b0001, 4'b0010));
    tbl.push_back(mkv( 0, 2'b11, 0, 0, 0, 0, 4'b1111, 4'b0000, 4'b0010));
    tbl.push_back(mkv( 0, 2'b00, 1, 1, 1, 0, 4'h0,    4'b0000, 4'b0010));

    foreach (tbl[i]) send(tbl[i]);
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("drain_out_valid", bus.out_valid, 0);
    check("drain_ctl", {bus.pc_src, bus.reg_write, bus.mem_write, bus.cond_ex}, 0);
    check("drain_sb_empty", sbq.size(), 0);
    check("sat_exec_cnt", bus.exec_cnt, 15);

    // Backpressure: X loads, Y waits three cycles behind it
    bus.out_ready = 1'b0;
    send(mkv(14, 2'b11, 1, 0, 0, 0, 4'b0101, 4'b1001, 4'b0101));
    v = mkv(14, 2'b11, 0, 0, 1, 0, 4'b1010, 4'b0011, 4'b1010);
    drive(v);
    repeat (3) begin
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_ctl", {bus.pc_src, bus.reg_write, bus.mem_write, bus.cond_ex}, 4'b1001);
      check("stall_flags", bus.flags, 4'b0101);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    check("release_in_ready", bus.in_ready, 1);
    push_exp(v);
    @(posedge clk); #1;

    // Clear wins over the increment of the same transfer
    v = mkv(14, 2'b00, 0, 1, 0, 0, 4'h0, 4'b0101, 4'b1010);
    v.clr = 1'b1;
    send(v);
    send(mkv(15, 2'b11, 0, 0, 0, 0, 4'h0, 4'b0000, 4'b1010));
    idle();
    repeat (2) @(posedge clk);
    #1;

    // Reset asserted while a result is stalled
    bus.out_ready = 1'b0;
    send(mkv(14, 2'b11, 0, 0, 0, 0, 4'b1111, 4'b0001, 4'b1111));
    idle();
    check("prerst_flags", bus.flags, 4'b1111);
    check("prerst_out_valid", bus.out_valid, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_flags", bus.flags, 0);
    check("midrst_ctl", {bus.pc_src, bus.reg_write, bus.mem_write, bus.cond_ex}, 0);
    check("midrst_cnts", {bus.exec_cnt, bus.skip_cnt}, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    sbq.delete();
    m_ex = '0;
    m_sk = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;

    send(mkv( 0, 2'b11, 0, 1, 0, 0, 4'hf, 4'b0000, 4'b0000));
    send(mkv( 3, 2'b00, 1, 0, 0, 0, 4'h0, 4'b1001, 4'b0000));
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("final_sb_empty", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
